// File: rtl/ship_placer.sv
// ship_placer -- interactive ship placement for the battleship board.
//
// Turns debounced player buttons into a cursor and orientation. Each requested
// placement is checked cell by cell for collisions, and accepted ships are
// written cell by cell into the board matrix that the VGA ship drawer reads.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   btn_up/down/left/right cursor moves (level inputs, rising edges act)
//   btn_rotate             toggle orientation
//   btn_place              request placement of the current ship
//   start                  clear the board and begin a new game
//   matrix                 board [y][x], each cell 0 or SHIP_CODE
//   cursor_x, cursor_y     head cell of the ship being placed
//   vertical               0: ship extends +x, 1: ship extends +y
//   ship_len               length of the current ship (0 once all are placed)
//   ships_placed           ships accepted so far
//   busy                   high while checking or writing a placement
//   err_collision          one-cycle pulse when a placement is rejected
//   done                   high once every ship is placed
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset, board and cursor frozen until start
// S_CLEAR | one cycle: empty board, cursor (0,0), horizontal, count 0
// S_PLACE | cursor moves / rotates, place begins a check
// S_CHECK | examine one ship cell per cycle for a collision
// S_WRITE | write one ship cell per cycle
// S_DONE  | all ships placed, waiting for start

module ship_placer #(
    parameter int MATRIX_SIZE = 5,
    parameter int NUM_SHIPS   = 3,
    parameter int SHIP_CODE   = 6
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         btn_up,
    input  logic                                         btn_down,
    input  logic                                         btn_left,
    input  logic                                         btn_right,
    input  logic                                         btn_rotate,
    input  logic                                         btn_place,
    input  logic                                         start,
    output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][31:0] matrix,
    output logic [2:0]                                   cursor_x,
    output logic [2:0]                                   cursor_y,
    output logic                                         vertical,
    output logic [2:0]                                   ship_len,
    output logic [2:0]                                   ships_placed,
    output logic                                         busy,
    output logic                                         err_collision,
    output logic                                         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLACE,
        S_CHECK,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [2:0] LP_NUM  = 3'(NUM_SHIPS);
    localparam logic [2:0] LP_SIZE = 3'(MATRIX_SIZE);
    localparam logic [2:0] LP_LAST = 3'(MATRIX_SIZE - 1);

    state_t r_state, w_state_nxt;

    // {start, place, rotate, up, down, left, right}, bit 6 has top priority
    logic [6:0] r_btn_prev;
    logic [6:0] w_btn;
    logic [6:0] w_edge;

    // one bit per cell; the SHIP_CODE value is only formed at the output
    logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0] r_cells, w_cells_nxt;

    logic [2:0] r_cx, r_cy, r_idx, r_placed;
    logic [2:0] w_cx_nxt, w_cy_nxt, w_idx_nxt, w_placed_nxt;
    logic       r_vert, w_vert_nxt;
    logic       r_err, w_err_nxt;

    logic [2:0] w_len;
    logic [2:0] w_room;
    logic [2:0] w_lim_x, w_lim_y;
    logic [2:0] w_tx, w_ty;
    logic       w_hit, w_last;

    assign w_btn  = {start, btn_place, btn_rotate, btn_up, btn_down, btn_left, btn_right};
    assign w_edge = w_btn & ~r_btn_prev;

    assign w_len  = LP_NUM - r_placed;
    // highest head coordinate on the extension axis that keeps the ship on board
    assign w_room = LP_SIZE - w_len;
    assign w_lim_x = r_vert ? LP_LAST : w_room;
    assign w_lim_y = r_vert ? w_room : LP_LAST;

    // cell under examination during CHECK / WRITE
    assign w_tx   = r_cx + (r_vert ? 3'd0 : r_idx);
    assign w_ty   = r_cy + (r_vert ? r_idx : 3'd0);
    assign w_hit  = r_cells[w_ty][w_tx];
    assign w_last = (r_idx == w_len - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cells_nxt  = r_cells;
        w_cx_nxt     = r_cx;
        w_cy_nxt     = r_cy;
        w_vert_nxt   = r_vert;
        w_idx_nxt    = r_idx;
        w_placed_nxt = r_placed;
        w_err_nxt    = 1'b0;

        if (w_edge[6]) begin
            // start aborts anything in flight; CLEAR wipes partial writes
            w_state_nxt = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    w_cells_nxt  = '0;
                    w_cx_nxt     = 3'd0;
                    w_cy_nxt     = 3'd0;
                    w_vert_nxt   = 1'b0;
                    w_placed_nxt = 3'd0;
                    w_state_nxt  = S_PLACE;
                end
                S_PLACE: begin
                    if (w_edge[5]) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_CHECK;
                    end else if (w_edge[4]) begin
                        w_vert_nxt = ~r_vert;
                        if (!r_vert) begin
                            w_cy_nxt = (r_cy > w_room) ? w_room : r_cy;
                        end else begin
                            w_cx_nxt = (r_cx > w_room) ? w_room : r_cx;
                        end
                    end else if (w_edge[3]) begin
                        if (r_cy != 3'd0) w_cy_nxt = r_cy - 3'd1;
                    end else if (w_edge[2]) begin
                        if (r_cy < w_lim_y) w_cy_nxt = r_cy + 3'd1;
                    end else if (w_edge[1]) begin
                        if (r_cx != 3'd0) w_cx_nxt = r_cx - 3'd1;
                    end else if (w_edge[0]) begin
                        if (r_cx < w_lim_x) w_cx_nxt = r_cx + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        w_err_nxt   = 1'b1;
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_PLACE;
                    end else if (w_last) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
                S_WRITE: begin
                    w_cells_nxt[w_ty][w_tx] = 1'b1;
                    if (w_last) begin
                        w_placed_nxt = r_placed + 3'd1;
                        w_idx_nxt    = 3'd0;
                        w_cx_nxt     = 3'd0;
                        w_cy_nxt     = 3'd0;
                        w_vert_nxt   = 1'b0;
                        w_state_nxt  = (r_placed + 3'd1 == LP_NUM) ? S_DONE : S_PLACE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= '0;
            r_cells    <= '0;
            r_cx       <= 3'd0;
            r_cy       <= 3'd0;
            r_vert     <= 1'b0;
            r_idx      <= 3'd0;
            r_placed   <= 3'd0;
            r_err      <= 1'b0;
        end else begin
            r_btn_prev <= w_btn;
            r_cells    <= w_cells_nxt;
            r_cx       <= w_cx_nxt;
            r_cy       <= w_cy_nxt;
            r_vert     <= w_vert_nxt;
            r_idx      <= w_idx_nxt;
            r_placed   <= w_placed_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        matrix = '0;
        for (int y = 0; y < MATRIX_SIZE; y++) begin
            for (int x = 0; x < MATRIX_SIZE; x++) begin
                matrix[y][x] = r_cells[y][x] ? 32'(SHIP_CODE) : 32'd0;
            end
        end
    end

    assign cursor_x      = r_cx;
    assign cursor_y      = r_cy;
    assign vertical      = r_vert;
    assign ship_len      = w_len;
    assign ships_placed  = r_placed;
    assign busy          = (r_state == S_CHECK) || (r_state == S_WRITE);
    assign err_collision = r_err;
    assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_ship_placer.sv
// tb_ship_placer -- self-checking bench for ship_placer.
// A placement-level model (modes, a per-operation cycle counter, a board array)
// predicts every output; a negedge process compares the DUT against it each
// cycle. A directed game with literal expectations is followed by random play.

module tb_ship_placer;

    localparam int N    = 5;
    localparam int NS   = 3;
    localparam int CODE = 6;

    localparam logic [6:0] B_START = 7'b1000000;
    localparam logic [6:0] B_PLACE = 7'b0100000;
    localparam logic [6:0] B_ROT   = 7'b0010000;
    localparam logic [6:0] B_UP    = 7'b0001000;
    localparam logic [6:0] B_DOWN  = 7'b0000100;
    localparam logic [6:0] B_LEFT  = 7'b0000010;
    localparam logic [6:0] B_RIGHT = 7'b0000001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] btns = '0;

    logic [N-1:0][N-1:0][31:0] matrix;
    logic [2:0] cursor_x, cursor_y, ship_len, ships_placed;
    logic       vertical, busy, err_collision, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ship_placer #(.MATRIX_SIZE(N), .NUM_SHIPS(NS), .SHIP_CODE(CODE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up       (btns[3]),
        .btn_down     (btns[2]),
        .btn_left     (btns[1]),
        .btn_right    (btns[0]),
        .btn_rotate   (btns[4]),
        .btn_place    (btns[5]),
        .start        (btns[6]),
        .matrix       (matrix),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .vertical     (vertical),
        .ship_len     (ship_len),
        .ships_placed (ships_placed),
        .busy         (busy),
        .err_collision(err_collision),
        .done         (done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_CLEAR, M_PLACE, M_BUSY, M_DONE} mmode_t;

    mmode_t     m_mode = M_IDLE;
    int         m_board [N][N];
    int         m_cx = 0, m_cy = 0, m_placed = 0;
    bit         m_vert = 0, m_err = 0;
    logic [6:0] m_prev = '0;
    // placement in flight: cycles since the place edge, length, head, first hit
    int         m_t = 0, m_len = 0, m_hx = 0, m_hy = 0, m_k = -1;
    bit         m_hv = 0;

    function automatic bit fits(int x, int y, bit v, int len);
        for (int i = 0; i < len; i++) begin
            int px, py;
            px = v ? x : x + i;
            py = v ? y + i : y;
            if (px < 0 || px >= N || py < 0 || py >= N) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        for (int y = 0; y < N; y++) for (int x = 0; x < N; x++) m_board[y][x] = 0;
        m_cx = 0; m_cy = 0; m_vert = 0; m_placed = 0; m_err = 0; m_prev = '0;
        m_t = 0; m_k = -1;
    endtask

    task automatic model_step(input logic [6:0] b);
        logic [6:0] e;
        int len;
        e = b & ~m_prev;
        m_prev = b;
        m_err = 0;
        len = NS - m_placed;
        if (e[6]) begin
            m_mode = M_CLEAR;
        end else begin
            case (m_mode)
                M_CLEAR: begin
                    for (int y = 0; y < N; y++) for (int x = 0; x < N; x++) m_board[y][x] = 0;
                    m_cx = 0; m_cy = 0; m_vert = 0; m_placed = 0;
                    m_mode = M_PLACE;
                end
                M_PLACE: begin
                    if (e[5]) begin
                        m_len = len; m_hx = m_cx; m_hy = m_cy; m_hv = m_vert;
                        m_k = -1;
                        for (int i = len - 1; i >= 0; i--) begin
                            if (m_board[m_vert ? m_cy + i : m_cy][m_vert ? m_cx : m_cx + i] == CODE)
                                m_k = i;
                        end
                        m_t = 0;
                        m_mode = M_BUSY;
                    end else if (e[4]) begin
                        m_vert = !m_vert;
                        if (m_vert) begin
                            if (m_cy > N - len) m_cy = N - len;
                        end else begin
                            if (m_cx > N - len) m_cx = N - len;
                        end
                    end else if (e[3]) begin
                        if (fits(m_cx, m_cy - 1, m_vert, len)) m_cy--;
                    end else if (e[2]) begin
                        if (fits(m_cx, m_cy + 1, m_vert, len)) m_cy++;
                    end else if (e[1]) begin
                        if (fits(m_cx - 1, m_cy, m_vert, len)) m_cx--;
                    end else if (e[0]) begin
                        if (fits(m_cx + 1, m_cy, m_vert, len)) m_cx++;
                    end
                end
                M_BUSY: begin
                    m_t++;
                    if (m_k >= 0) begin
                        if (m_t == m_k + 1) begin
                            m_mode = M_PLACE;
                            m_err = 1;
                        end
                    end else begin
                        if (m_t >= m_len + 1) begin
                            int o;
                            o = m_t - m_len - 1;
                            m_board[m_hv ? m_hy + o : m_hy][m_hv ? m_hx : m_hx + o] = CODE;
                        end
                        if (m_t == 2 * m_len) begin
                            m_placed++;
                            m_cx = 0; m_cy = 0; m_vert = 0;
                            m_mode = (m_placed == NS) ? M_DONE : M_PLACE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(btns);
    end

    // ---------------- per-cycle compare ----------------
    int cmp_cells;
    always @(negedge clk) begin
        cmp_cells = 0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (matrix[y][x] != 32'(m_board[y][x])) cmp_cells++;
        check("matrix_cells_differing", cmp_cells, 0);
        check("cursor_x", int'(cursor_x), m_cx);
        check("cursor_y", int'(cursor_y), m_cy);
        check("vertical", int'(vertical), int'(m_vert));
        check("ship_len", int'(ship_len), NS - m_placed);
        check("ships_placed", int'(ships_placed), m_placed);
        check("busy", int'(busy), int'(m_mode == M_BUSY));
        check("err_collision", int'(err_collision), int'(m_err));
        check("done", int'(done), int'(m_mode == M_DONE));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic [6:0] b);
        @(negedge clk);
        #1;
        btns = b;
    endtask

    task automatic press(input logic [6:0] b);
        tick(b);
        tick('0);
    endtask

    function automatic int ship_cells();
        int c;
        c = 0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (matrix[y][x] == 32'(CODE)) c++;
        return c;
    endfunction

    function automatic logic [6:0] rand_btns();
        logic [6:0] b;
        b[6] = ($urandom_range(0, 79) == 0);
        b[5] = ($urandom_range(0, 5) == 0);
        b[4] = ($urandom_range(0, 4) == 0);
        b[3] = ($urandom_range(0, 2) == 0);
        b[2] = ($urandom_range(0, 2) == 0);
        b[1] = ($urandom_range(0, 2) == 0);
        b[0] = ($urandom_range(0, 2) == 0);
        return b;
    endfunction

    initial begin
        int cnt;
        rst_n = 1'b0;
        btns  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cursor_x", int'(cursor_x), 0);
        check("rst_ships_placed", int'(ships_placed), 0);
        check("rst_ship_len", int'(ship_len), 3);
        check("rst_busy_done_err", int'({busy, done, err_collision}), 0);
        check("rst_cells", ship_cells(), 0);
        rst_n = 1'b1;

        // start: PLACE two edges later
        press(B_START);
        tick('0);
        check("start_cursor", int'({cursor_x, cursor_y}), 0);
        check("start_ship_len", int'(ship_len), 3);
        check("model_len_pin", NS - m_placed, 3);

        // first ship horizontal at (0,0)
        tick(B_PLACE);
        cnt = 0;
        repeat (10) begin
            tick('0);
            if (busy) cnt++;
        end
        check("busy_cycles_len3", cnt, 6);
        check("cell_0_0", int'(matrix[0][0]), 6);
        check("cell_0_1", int'(matrix[0][1]), 6);
        check("cell_0_2", int'(matrix[0][2]), 6);
        check("cell_0_3", int'(matrix[0][3]), 0);
        check("placed_after_1", int'(ships_placed), 1);
        check("len_after_1", int'(ship_len), 2);

        // clamping with the length-2 ship
        repeat (5) press(B_RIGHT);
        check("right_clamp_x", int'(cursor_x), 3);
        press(B_ROT);
        check("rot_vertical", int'(vertical), 1);
        check("rot_keeps_x", int'(cursor_x), 3);
        repeat (4) press(B_DOWN);
        check("down_clamp_y", int'(cursor_y), 3);

        // vertical at (1,0) hits [0][1]
        repeat (2) press(B_LEFT);
        repeat (3) press(B_UP);
        check("coll_head", int'({cursor_x, cursor_y}), int'({3'd1, 3'd0}));
        tick(B_PLACE);
        tick('0);
        check("err_before", int'(err_collision), 0);
        tick('0);
        check("err_pulse", int'(err_collision), 1);
        check("busy_after_coll", int'(busy), 0);
        tick('0);
        check("err_after", int'(err_collision), 0);
        check("coll_cells_unchanged", ship_cells(), 3);

        // second ship horizontal at (1,1), third at (0,4)
        press(B_ROT);
        press(B_DOWN);
        tick(B_PLACE);
        repeat (6) tick('0);
        check("placed_after_2", int'(ships_placed), 2);
        check("cell_1_2", int'(matrix[1][2]), 6);
        repeat (4) press(B_DOWN);
        check("len1_down_y", int'(cursor_y), 4);
        tick(B_PLACE);
        repeat (4) tick('0);
        check("done_high", int'(done), 1);
        check("done_cells", ship_cells(), 6);
        check("done_len", int'(ship_len), 0);

        press(B_START);
        tick('0);
        check("restart_cells", ship_cells(), 0);
        check("restart_placed", int'(ships_placed), 0);

        // start and place in the same cycle
        tick(B_PLACE);
        repeat (8) tick('0);
        check("pre_tie_cells", ship_cells(), 3);
        tick(B_START | B_PLACE);
        tick('0);
        check("tie_not_busy", int'(busy), 0);
        tick('0);
        check("tie_cells", ship_cells(), 0);
        check("tie_placed", int'(ships_placed), 0);

        // start mid-WRITE
        tick(B_PLACE);
        repeat (6) tick('0);
        check("midwrite_busy", int'(busy), 1);
        check("midwrite_cells", ship_cells(), 2);
        tick(B_START);
        tick('0);
        tick('0);
        check("abort_cells", ship_cells(), 0);
        check("abort_busy", int'(busy), 0);

        // reset mid-WRITE
        tick(B_PLACE);
        repeat (6) tick('0);
        check("rw_cells_before", ship_cells(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_cells", ship_cells(), 0);
        check("rw_busy", int'(busy), 0);
        check("rw_len", int'(ship_len), 3);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // random play
        press(B_START);
        repeat (4000) tick(rand_btns());
        repeat (3) tick('0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ship_placer.md
# ship_placer

Interactive ship-placement controller for the 5x5 battleship board. It turns debounced player buttons into a cursor position and orientation. It checks each requested placement against the board for collisions and writes accepted ships into the board matrix cell by cell. The matrix is the board consumed by the ship block drawer in the VGA path, and ship cells are written with code 6.

## Interface

Parameters:
- `MATRIX_SIZE`, 5: board dimension in cells per side.
- `NUM_SHIPS`, 3: number of ships per game, range 1..5. Ship k (k = 0..NUM_SHIPS-1) has length NUM_SHIPS-k.
- `SHIP_CODE`, 6: value written to occupied cells.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in, 1: system clock.
- `rst_n` in, 1: asynchronous active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in, 1 each: cursor move requests. Level inputs, synchronous and debounced upstream.
- `btn_rotate` in, 1: toggles orientation.
- `btn_place` in, 1: requests placement of the current ship.
- `start` in, 1: clears the board and begins a new game.
- `matrix` out, int [4:0][4:0]: board, indexed [y][x]. Holds 0 (empty) or SHIP_CODE.
- `cursor_x`, `cursor_y` out, 3 each: head cell of the ship being placed.
- `vertical` out, 1: 0 means the ship extends in +x, 1 means it extends in +y.
- `ship_len` out, 3: length of the current ship.
- `ships_placed` out, 3: count of ships accepted so far.
- `busy` out, 1: high in CHECK or WRITE.
- `err_collision` out, 1: one-cycle pulse when a placement is rejected.
- `done` out, 1: high while in DONE.

## Operation

- All buttons are rising-edge detected against a registered copy of the previous level. Only edges act.
- When several edges occur in the same cycle, exactly one acts, in priority order: start > place > rotate > up > down > left > right. The other edges are discarded.
- States:
  - IDLE: the board and cursor are frozen. Start goes to CLEAR.
  - CLEAR: one cycle. All 25 cells become 0, cursor goes to (0,0), vertical=0, ships_placed=0. Next state is PLACE.
  - PLACE: move and rotate edges update the cursor. Place goes to CHECK with cell index i=0.
  - CHECK: one cycle per cell. Examines the cell at the head offset by i along the orientation.
    - If the cell equals SHIP_CODE: go to PLACE and pulse err_collision.
    - Else if i = ship_len-1: go to WRITE with i=0.
    - Else i increments.
  - WRITE: one cycle per cell. Writes SHIP_CODE at offset i. After the last cell, ships_placed increments, then the state goes to DONE if ships_placed reaches NUM_SHIPS, else to PLACE. Entering PLACE this way resets the cursor to (0,0) and vertical to 0.
  - DONE: done=1. Start goes to CLEAR.
- Cursor clamping:
  - The ship must always fit on the board: head_along + ship_len - 1 ≤ MATRIX_SIZE-1 on the extension axis, and 0..4 on the other axis.
  - A move that would violate this is ignored; the cursor does not wrap.
  - Rotate always toggles, then clamps the new extension axis coordinate down to MATRIX_SIZE - ship_len.
- Start edges are honoured in every state, including mid-CHECK or mid-WRITE. They abort the operation and go to CLEAR; partially written cells are cleared.
- Move, rotate and place edges during CHECK, WRITE, CLEAR, IDLE or DONE are ignored.
- `ship_len` = NUM_SHIPS - ships_placed, combinational from the registered count. It is 0 in DONE.

## Timing

- Reset values:
  - state IDLE
  - matrix all 0
  - cursor (0,0)
  - vertical 0
  - ships_placed 0
  - busy, err_collision and done all 0
  - edge-detect registers 0. A button held through reset release therefore fires once.
- Edge-to-effect: a button level that is high at clock edge E with the previous registered level low takes effect at E. The updated cursor or state is visible after E.
- Placement latency for a ship of length L is exactly 2L cycles from the place edge to the return to PLACE or DONE.
  - CHECK occupies L cycles and WRITE occupies L cycles.
  - Matrix cell i updates at edge E+L+1+i.
- A collision at CHECK index k returns to PLACE at edge E+k+1. err_collision is high for exactly the following cycle, and the matrix is unchanged.
- CLEAR takes 1 cycle. PLACE is entered 2 edges after the start edge.

## Test plan

- Reset, then pulse start → after 2 cycles: state PLACE, cursor (0,0), vertical 0, ship_len 3, every matrix cell 0.
- Pulse place at (0,0) horizontal → busy for 6 cycles; [0][0], [0][1] and [0][2] become 6; ships_placed=1; ship_len=2.
- Second ship: press right 5 times → cursor_x stops at 3. Rotate → vertical=1 and cursor_x stays 3. Press down 4 times → cursor_y stops at 3.
- Place the length-2 ship vertically at (1,0) → collision at [0][1]. err_collision is a 1-cycle pulse 1 cycle after the place edge, and the matrix is unchanged.
- Place all three ships legally → done=1, matrix has exactly 6 cells equal to 6. Then pulse start → all cells 0, ships_placed=0.
- Assert start in the same cycle as place, and separately during WRITE → start wins and the board is cleared. Assert rst_n low mid-WRITE → all outputs go to their reset values immediately.
